// File: rtl/mips_cpu_pkg.sv
// Shared MIPS core definitions: load opcodes and load classification.
package mips_cpu_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LWL = 6'h22;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LWR = 6'h26;

    function automatic logic is_load(input logic [5:0] opcode);
        case (opcode)
            OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: return 1'b1;
            default:                                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_load_merge.sv
// Partial-load lane merge: combines raw writeback data with the stored register value.
module mips_cpu_load_merge
    import mips_cpu_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    output logic [31:0] merged_o
);

    always_comb begin
        merged_o = new_i;
        case (opcode_i)
            OP_LB:  merged_o = {{24{new_i[7]}}, new_i[7:0]};
            OP_LBU: merged_o = {24'h0, new_i[7:0]};
            OP_LH:  merged_o = {{16{new_i[15]}}, new_i[15:0]};
            OP_LHU: merged_o = {16'h0, new_i[15:0]};
            OP_LWL: begin
                case (offset_i)
                    2'd0:    merged_o = {new_i[7:0],  old_i[23:0]};
                    2'd1:    merged_o = {new_i[15:0], old_i[15:0]};
                    2'd2:    merged_o = {new_i[23:0], old_i[7:0]};
                    default: merged_o = new_i;
                endcase
            end
            OP_LWR: begin
                case (offset_i)
                    2'd0:    merged_o = new_i;
                    2'd1:    merged_o = {old_i[31:24], new_i[31:8]};
                    2'd2:    merged_o = {old_i[31:16], new_i[31:16]};
                    default: merged_o = {old_i[31:8],  new_i[31:24]};
                endcase
            end
            default: merged_o = new_i;
        endcase
    end

endmodule

// File: rtl/mips_cpu_regfile_mp.sv
// Multi-read-port register file with hardwired-zero r0, write-through bypass
// and a per-register load scoreboard for multicycle memory loads.
module mips_cpu_regfile_mp
    import mips_cpu_pkg::*;
#(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NRD    = 2,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*32-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [31:0]       wr_data,
    input  logic [5:0]        wr_opcode,
    input  logic [1:0]        wr_offset,
    input  logic              clm_en,
    input  logic [AW-1:0]     clm_addr,
    input  logic              flush,
    input  logic [AW-1:0]     dbg_addr,
    output logic [31:0]       dbg_data,
    output logic [31:0]       regv0
);

    logic [31:0]      regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] busy_wr;
    logic             wr_hit;
    logic [31:0]      wr_old;
    logic [31:0]      wr_merged;

    assign wr_hit = wr_en && (wr_addr != '0);
    assign wr_old = regs_q[wr_addr];

    mips_cpu_load_merge u_merge (
        .opcode_i (wr_opcode),
        .offset_i (wr_offset),
        .old_i    (wr_old),
        .new_i    (wr_data),
        .merged_o (wr_merged)
    );

    // busy_wr is the post-commit view seen by bypassed readers; claims are
    // applied last so a claim beats both a same-cycle commit and a flush.
    always_comb begin
        busy_wr = busy_q;
        if (wr_hit && is_load(wr_opcode)) begin
            busy_wr[wr_addr] = 1'b0;
        end
        busy_d = flush ? '0 : busy_wr;
        if (clm_en && (clm_addr != '0)) begin
            busy_d[clm_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            if (wr_hit) begin
                regs_q[wr_addr] <= wr_merged;
            end
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] sel;
        logic          byp;
        assign sel = rd_addr[i*AW +: AW];
        assign byp = (BYPASS != 0) && wr_hit && (wr_addr == sel);
        assign rd_data[i*32 +: 32] = byp ? wr_merged : regs_q[sel];
        assign rd_busy[i] = (BYPASS != 0) ? busy_wr[sel] : busy_q[sel];
    end

    assign dbg_data = regs_q[dbg_addr];

    if (NREGS > 2) begin : g_v0
        assign regv0 = regs_q[2];
    end else begin : g_no_v0
        assign regv0 = '0;
    end

endmodule

// File: tb/tb_mips_cpu_regfile_mp.sv
// Directed and randomized checks of the register file: default and a
// 16-register, 3-port, non-bypassed instance.
module tb_mips_cpu_regfile_mp;
    import mips_cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Instance A: NREGS=32, NRD=2, BYPASS=1
    logic        a_reset, a_wr_en, a_clm_en, a_flush;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [4:0]  a_wr_addr, a_clm_addr, a_dbg_addr;
    logic [31:0] a_wr_data, a_dbg_data, a_regv0;
    logic [5:0]  a_wr_opcode;
    logic [1:0]  a_wr_offset;

    // Instance B: NREGS=16, NRD=3, BYPASS=0
    logic        b_reset, b_wr_en, b_clm_en, b_flush;
    logic [11:0] b_rd_addr;
    logic [95:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic [3:0]  b_wr_addr, b_clm_addr, b_dbg_addr;
    logic [31:0] b_wr_data, b_dbg_data, b_regv0;
    logic [5:0]  b_wr_opcode;
    logic [1:0]  b_wr_offset;

    mips_cpu_regfile_mp #(.NREGS(32), .NRD(2), .BYPASS(1)) u_dut_a (
        .clk(clk), .reset(a_reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .rd_busy(a_rd_busy), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .wr_opcode(a_wr_opcode), .wr_offset(a_wr_offset), .clm_en(a_clm_en),
        .clm_addr(a_clm_addr), .flush(a_flush), .dbg_addr(a_dbg_addr),
        .dbg_data(a_dbg_data), .regv0(a_regv0)
    );

    mips_cpu_regfile_mp #(.NREGS(16), .NRD(3), .BYPASS(0)) u_dut_b (
        .clk(clk), .reset(b_reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .rd_busy(b_rd_busy), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .wr_opcode(b_wr_opcode), .wr_offset(b_wr_offset), .clm_en(b_clm_en),
        .clm_addr(b_clm_addr), .flush(b_flush), .dbg_addr(b_dbg_addr),
        .dbg_data(b_dbg_data), .regv0(b_regv0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle;
        a_wr_en = 1'b0; a_clm_en = 1'b0; a_flush = 1'b0;
        a_wr_opcode = 6'h00; a_wr_offset = 2'd0;
    endtask

    task automatic a_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [5:0] op, input logic [1:0] off);
        a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data;
        a_wr_opcode = op; a_wr_offset = off;
    endtask

    task automatic a_commit(input logic [4:0] addr, input logic [31:0] data,
                            input logic [5:0] op, input logic [1:0] off);
        a_write(addr, data, op, off);
        tick;
        a_idle;
        #1;
    endtask

    task automatic a_claim(input logic [4:0] addr);
        a_clm_en = 1'b1; a_clm_addr = addr;
    endtask

    // Independent reference for the lane merge, written as shift/mask arithmetic.
    function automatic logic [31:0] ref_merge(input logic [5:0] op, input logic [1:0] off,
                                              input logic [31:0] old, input logic [31:0] d);
        int unsigned sh;
        case (op)
            6'h20: return {{24{d[7]}}, d[7:0]};
            6'h24: return d & 32'h0000_00FF;
            6'h21: return {{16{d[15]}}, d[15:0]};
            6'h25: return d & 32'h0000_FFFF;
            6'h22: begin
                sh = 8 * (3 - int'(off));
                return (d << sh) | (old & ((32'h1 << sh) - 32'h1));
            end
            6'h26: begin
                sh = 8 * int'(off);
                return (d >> sh) | (old & ~(32'hFFFF_FFFF >> sh));
            end
            default: return d;
        endcase
    endfunction

    logic [31:0] m_regs [16];
    logic [15:0] m_busy;
    logic [31:0] n_regs [16];
    logic [15:0] n_busy;
    logic [5:0]  op_tab [9];

    initial begin
        op_tab = '{6'h00, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h3F};
        a_reset = 1'b1; b_reset = 1'b1;
        a_idle;
        a_wr_addr = '0; a_wr_data = '0; a_clm_addr = '0; a_dbg_addr = '0; a_rd_addr = '0;
        b_wr_en = 1'b0; b_clm_en = 1'b0; b_flush = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_wr_opcode = '0; b_wr_offset = '0; b_clm_addr = '0; b_dbg_addr = '0; b_rd_addr = '0;
        tick;
        a_reset = 1'b0; b_reset = 1'b0;

        // Reset state
        a_rd_addr = {5'd5, 5'd0};
        #1;
        chk("rst_rd0", a_rd_data[31:0], 32'h0);
        chk("rst_rd1", a_rd_data[63:32], 32'h0);
        chk("rst_regv0", a_regv0, 32'h0);
        chk("rst_busy", {30'h0, a_rd_busy}, 32'h0);

        // Write, claim, then reset (overriding a concurrent write)
        a_write(5'd5, 32'hDEAD_BEEF, 6'h00, 2'd0);
        a_claim(5'd6);
        tick;
        a_idle;
        a_commit(5'd2, 32'h0000_0011, 6'h00, 2'd0);
        a_rd_addr = {5'd6, 5'd5}; a_dbg_addr = 5'd5;
        #1;
        chk("wr_r5", a_rd_data[31:0], 32'hDEAD_BEEF);
        chk("clm_r6", {31'h0, a_rd_busy[1]}, 32'h1);
        chk("regv0_r2", a_regv0, 32'h0000_0011);
        chk("dbg_r5", a_dbg_data, 32'hDEAD_BEEF);
        a_reset = 1'b1;
        a_write(5'd5, 32'h0000_0001, 6'h00, 2'd0);
        a_claim(5'd5);
        tick;
        a_reset = 1'b0;
        a_idle;
        #1;
        chk("rst2_r5", a_rd_data[31:0], 32'h0);
        chk("rst2_busy", {30'h0, a_rd_busy}, 32'h0);
        chk("rst2_regv0", a_regv0, 32'h0);
        chk("rst2_dbg", a_dbg_data, 32'h0);

        // r0 protection
        a_rd_addr = {5'd0, 5'd0};
        a_write(5'd0, 32'h1234_5678, 6'h00, 2'd0);
        a_claim(5'd0);
        #1;
        chk("r0_byp", a_rd_data[31:0], 32'h0);
        tick;
        a_idle;
        #1;
        chk("r0_data", a_rd_data[31:0], 32'h0);
        chk("r0_busy", {30'h0, a_rd_busy}, 32'h0);

        // Merge modes
        a_rd_addr = {5'd4, 5'd3};
        a_commit(5'd3, 32'hAABB_CCDD, 6'h00, 2'd0);
        a_commit(5'd3, 32'h0000_0080, OP_LB, 2'd0);
        chk("lb", a_rd_data[31:0], 32'hFFFF_FF80);
        a_commit(5'd3, 32'hAABB_CCDD, 6'h00, 2'd0);
        a_commit(5'd3, 32'h1122_3344, OP_LWL, 2'd1);
        chk("lwl_off1", a_rd_data[31:0], 32'h3344_CCDD);
        a_commit(5'd3, 32'hAABB_CCDD, 6'h00, 2'd0);
        a_commit(5'd3, 32'h1122_3344, OP_LWR, 2'd2);
        chk("lwr_off2", a_rd_data[31:0], 32'hAABB_1122);
        a_commit(5'd3, 32'h0000_8001, OP_LH, 2'd0);
        chk("lh", a_rd_data[31:0], 32'hFFFF_8001);
        a_commit(5'd3, 32'h1234_56F0, OP_LBU, 2'd0);
        chk("lbu", a_rd_data[31:0], 32'h0000_00F0);
        a_commit(5'd3, 32'h1234_8765, OP_LHU, 2'd0);
        chk("lhu", a_rd_data[31:0], 32'h0000_8765);
        a_commit(5'd3, 32'hAABB_CCDD, 6'h00, 2'd0);
        a_commit(5'd3, 32'h1122_3344, OP_LWL, 2'd0);
        chk("lwl_off0", a_rd_data[31:0], 32'h44BB_CCDD);
        a_commit(5'd3, 32'h1122_3344, OP_LWR, 2'd3);
        chk("lwr_off3", a_rd_data[31:0], 32'h44BB_CC11);
        // lwl then lwr chained through storage
        a_commit(5'd4, 32'h1122_3344, OP_LWL, 2'd1);
        a_commit(5'd4, 32'h5566_7788, OP_LWR, 2'd2);
        chk("lwl_lwr_chain", a_rd_data[63:32], 32'h3344_5566);

        // Bypass, including through the merge
        a_rd_addr = {5'd7, 5'd3};
        a_write(5'd7, 32'hCAFE_F00D, 6'h00, 2'd0);
        #1;
        chk("byp_same_cycle", a_rd_data[63:32], 32'hCAFE_F00D);
        chk("byp_other_port", a_rd_data[31:0], 32'h44BB_CC11);
        tick;
        a_idle;
        #1;
        chk("byp_stored", a_rd_data[63:32], 32'hCAFE_F00D);
        a_write(5'd3, 32'h0000_007F, OP_LB, 2'd0);
        #1;
        chk("byp_merged", a_rd_data[31:0], 32'h0000_007F);
        tick;
        a_idle;

        // Scoreboard
        a_rd_addr = {5'd10, 5'd9};
        a_claim(5'd9);
        tick;
        a_idle;
        #1;
        chk("sb_claim", {31'h0, a_rd_busy[0]}, 32'h1);
        a_commit(5'd9, 32'h0000_0099, 6'h00, 2'd0);
        chk("sb_alu_keeps", {31'h0, a_rd_busy[0]}, 32'h1);
        chk("sb_alu_data", a_rd_data[31:0], 32'h0000_0099);
        a_write(5'd9, 32'h0000_1234, OP_LW, 2'd0);
        a_claim(5'd9);
        #1;
        chk("sb_byp_busy", {31'h0, a_rd_busy[0]}, 32'h0);
        chk("sb_byp_data", a_rd_data[31:0], 32'h0000_1234);
        tick;
        a_idle;
        #1;
        chk("sb_claim_wins", {31'h0, a_rd_busy[0]}, 32'h1);
        a_write(5'd9, 32'h0000_5678, OP_LW, 2'd0);
        #1;
        chk("sb_lw_byp", {31'h0, a_rd_busy[0]}, 32'h0);
        tick;
        a_idle;
        #1;
        chk("sb_lw_clear", {31'h0, a_rd_busy[0]}, 32'h0);
        chk("sb_lw_data", a_rd_data[31:0], 32'h0000_5678);
        a_claim(5'd9);
        tick;
        a_idle;
        a_flush = 1'b1;
        a_claim(5'd10);
        tick;
        a_idle;
        #1;
        chk("flush_claim", {30'h0, a_rd_busy}, 32'h2);
        a_rd_addr = {5'd11, 5'd10};
        a_flush = 1'b1;
        a_write(5'd11, 32'h0000_0055, OP_LW, 2'd0);
        tick;
        a_idle;
        #1;
        chk("flush_busy", {30'h0, a_rd_busy}, 32'h0);
        chk("flush_commit", a_rd_data[63:32], 32'h0000_0055);

        // Instance B: no bypass
        b_rd_addr = {4'd0, 4'd7, 4'd0};
        b_wr_en = 1'b1; b_wr_addr = 4'd7; b_wr_data = 32'h0000_1111; b_wr_opcode = 6'h00;
        tick;
        b_wr_data = 32'hCAFE_F00D;
        #1;
        chk("nobyp_old", b_rd_data[63:32], 32'h0000_1111);
        tick;
        b_wr_en = 1'b0;
        #1;
        chk("nobyp_next", b_rd_data[63:32], 32'hCAFE_F00D);

        for (int r = 0; r < 16; r++) m_regs[r] = 32'h0;
        m_regs[7] = 32'hCAFE_F00D;
        m_busy = 16'h0;

        // Random sweep against the reference model
        for (int cyc = 0; cyc < 300; cyc++) begin
            b_wr_en     = ($urandom_range(0, 3) != 0);
            b_wr_addr   = 4'($urandom_range(0, 15));
            b_wr_data   = $urandom;
            b_wr_opcode = op_tab[$urandom_range(0, 8)];
            b_wr_offset = 2'($urandom_range(0, 3));
            b_clm_en    = ($urandom_range(0, 2) == 0);
            b_clm_addr  = 4'($urandom_range(0, 15));
            b_flush     = ($urandom_range(0, 15) == 0);
            b_rd_addr   = 12'($urandom_range(0, 4095));
            b_dbg_addr  = 4'($urandom_range(0, 15));

            n_regs = m_regs;
            n_busy = b_flush ? 16'h0 : m_busy;
            if (b_wr_en && b_wr_addr != 4'd0) begin
                n_regs[b_wr_addr] = ref_merge(b_wr_opcode, b_wr_offset, m_regs[b_wr_addr], b_wr_data);
                if (b_wr_opcode >= 6'h20 && b_wr_opcode <= 6'h26) n_busy[b_wr_addr] = 1'b0;
            end
            if (b_clm_en && b_clm_addr != 4'd0) n_busy[b_clm_addr] = 1'b1;

            tick;
            m_regs = n_regs;
            m_busy = n_busy;
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("sweep_data c%0d p%0d", cyc, p), b_rd_data[p*32 +: 32],
                    m_regs[b_rd_addr[p*4 +: 4]]);
                chk($sformatf("sweep_busy c%0d p%0d", cyc, p), {31'h0, b_rd_busy[p]},
                    {31'h0, m_busy[b_rd_addr[p*4 +: 4]]});
            end
            chk($sformatf("sweep_dbg c%0d", cyc), b_dbg_data, m_regs[b_dbg_addr]);
            chk($sformatf("sweep_regv0 c%0d", cyc), b_regv0, m_regs[2]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_cpu_regfile_mp.md
# mips_cpu_regfile_mp

Parametrised multi-read-port general-purpose register file for the MIPS CPU core, replacing the fixed two-port file. It adds several features: a configurable read-port count, a hardwired-zero `$0`, write-through bypass, and a per-register load scoreboard for multicycle memory loads. Partial-load lane merging (lb/lbu/lh/lhu/lwl/lwr) sits in a dedicated sub-module, and uses an explicit byte offset instead of a read-port value. It sits between decode/issue (reads, scoreboard claims) and writeback (commits).

## Interface
Parameters:
- `NREGS`, 32, register count; power of two, ≥2; `AW = $clog2(NREGS)`
- `NRD`, 2, number of combinational read ports, ≥1
- `BYPASS`, 1, 1 = same-cycle write visible on read ports and busy flags; 0 = visible next cycle

Ports (data width fixed at 32):
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all registers and busy bits
- `rd_addr`  in  NRD×AW  read selectors, packed, port i at `[i*AW +: AW]`
- `rd_data`  out  NRD×32  read data, packed
- `rd_busy`  out  NRD  1 = selected register has a pending load
- `wr_en`  in  1  write commit strobe
- `wr_addr`  in  AW  write destination
- `wr_data`  in  32  raw writeback data (ALU result or aligned memory word)
- `wr_opcode`  in  6  instruction opcode selecting merge mode
- `wr_offset`  in  2  effective-address byte offset for lwl/lwr
- `clm_en`  in  1  scoreboard claim: a load to `clm_addr` has issued
- `clm_addr`  in  AW  claimed destination
- `flush`  in  1  clears every busy bit (pipeline flush); registers untouched
- `dbg_addr`  in  AW  debug read selector
- `dbg_data`  out  32  debug read of `dbg_addr` (never bypassed)
- `regv0`  out  32  contents of register 2

## Operation
- Merge, by opcode. `old` is the current register value.
  - 0x20 lb: sign-extend `wr_data[7:0]`.
  - 0x24 lbu: zero-extend `wr_data[7:0]`.
  - 0x21 lh: sign-extend `wr_data[15:0]`.
  - 0x25 lhu: zero-extend `wr_data[15:0]`.
  - 0x22 lwl, by offset:
    - 0: `{wr_data[7:0], old[23:0]}`
    - 1: `{wr_data[15:0], old[15:0]}`
    - 2: `{wr_data[23:0], old[7:0]}`
    - 3: `wr_data`
  - 0x26 lwr, by offset:
    - 0: `wr_data`
    - 1: `{old[31:24], wr_data[31:8]}`
    - 2: `{old[31:16], wr_data[31:16]}`
    - 3: `{old[31:8], wr_data[31:24]}`
  - Any other opcode: `wr_data`.
- Register 0 always reads 0. Writes and claims to address 0 are ignored; its busy bit is never set.
- Write commit: on `wr_en` with `wr_addr≠0`, the merged value is written, and the busy bit clears if `wr_opcode` is a load opcode (0x20–0x26 above, plus 0x23 lw).
- Claim: on `clm_en` with `clm_addr≠0`, the busy bit is set.
- Read: `rd_data[i] = reg[rd_addr[i]]`. `rd_busy[i] = busy[rd_addr[i]]`.
- `BYPASS=1`: if `wr_en` is set and `wr_addr = rd_addr[i] ≠ 0`, then `rd_data[i]` shows the merged value. `rd_busy[i]` shows the post-commit busy state, excluding same-cycle claims.

## Timing
- Reset: all registers 0, all busy bits 0, effective the edge after `reset` is sampled high. `reset` overrides `wr_en`, `clm_en` and `flush`. Because outputs follow state, `rd_data`, `dbg_data` and `regv0` read 0 and `rd_busy` reads 0 after that edge.
- Write latency: 1 edge to storage. Read latency: 0 (combinational); with bypass, the new value is visible in the same cycle.
- Simultaneous events on one register:
  - Claim + load commit in the same cycle: claim wins, busy ends set (back-to-back loads).
  - `flush` + claim in the same cycle: claim wins.
  - `flush` + commit: commit still writes.
- A load commit to a non-busy register is legal. The data is written and busy stays 0.
- A non-load write leaves busy unchanged.
- lwl/lwr `old` is the stored value. There is no bypass into the merge itself: consecutive lwl then lwr to one register take two cycles and chain correctly through storage.
- No handshake stalls. The block never back-pressures.

## Structure
- Shared package `mips_cpu_pkg`:
  - opcode constants `OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR`
  - function `is_load(opcode)`
- Sub-module `mips_cpu_load_merge`: pure combinational, inputs (`opcode`, `offset`, `old`, `new`), output `merged`. It is instantiated once for the write port, and its output is reused for storage and bypass.
- Storage array, busy vector and read muxes are built with a generate loop over `NRD`.

## Test plan
- Reset then read: write 0xDEADBEEF to r5, assert `reset` one cycle → all `rd_data` = 0, `regv0` = 0, all `rd_busy` = 0.
- r0 protection: write 0x12345678 to r0, claim r0 → `rd_data` for r0 = 0, `rd_busy` = 0.
- Merge:
  - r3 = 0xAABBCCDD; lb with `wr_data` 0x00000080 → r3 = 0xFFFFFF80.
  - r3 = 0xAABBCCDD; lwl off 1, data 0x11223344 → r3 = 0x3344CCDD.
  - r3 = 0xAABBCCDD; lwr off 2, data 0x11223344 → r3 = 0xAABB1122.
- Bypass:
  - `BYPASS=1`: write 0xCAFEF00D to r7 while `rd_addr[1]`=7 → `rd_data[1]` = 0xCAFEF00D in the same cycle.
  - `BYPASS=0`: the same write shows the old value until the next cycle.
- Scoreboard:
  - Claim r9 → busy = 1.
  - ALU write to r9 → busy stays 1.
  - lw commit to r9 together with a new claim to r9 → busy stays 1.
  - Next lw commit → busy = 0.
  - `flush` clears any remaining busy bits.
- Parameter sweep: `NREGS` = 16, `NRD` = 3, random writes and reads checked against a reference model. All three ports are read concurrently, and `dbg_data`/`regv0` must match the model every cycle.
